// File: rtl/adc_dat_demux.sv
// adc_dat_demux
// Readback-side decoder for the tagged 132-bit word stream that the
// acquisition mux writes to DDR3. Each word carries a 4-bit tag in [131:128]
// and a 128-bit payload:
//   tag 1 = fill header, tag 2 = waveform header, tag 3 = ADC data,
//   tag 4 = XOR checksum of all preceding payloads of the fill.
// Headers are parsed and cross-checked, data words are unpacked into eight
// sign-extended 16-bit samples, and the checksum is recomputed and compared.
//
// Ports:
//   clk, reset                  system clock, async active-high reset
//   in_dat/in_valid/in_ready    tagged word input from the DDR3 read FIFO
//   smp_dat                     eight 16-bit samples, [15:0] oldest
//   smp_wfm_num                 waveform number the samples belong to
//   smp_last                    last data word of the waveform
//   smp_valid/smp_ready         sample word handshake
//   fill_num, fill_type,
//   num_fill_bursts,
//   num_waveforms, channel_tag  fields of the most recent fill header
//   fill_done/fill_ok           end-of-fill pulse and its status
//   err                         sticky per-fill error flags
//                               [0] tag, [1] marker, [2] field, [3] sequence,
//                               [4] checksum
module adc_dat_demux #(
  parameter logic [11:0] FIRST_WFM_NUM = 12'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [131:0] in_dat,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] smp_dat,
  output logic [11:0]  smp_wfm_num,
  output logic         smp_last,
  output logic         smp_valid,
  input  logic         smp_ready,
  output logic [23:0]  fill_num,
  output logic [1:0]   fill_type,
  output logic [22:0]  num_fill_bursts,
  output logic [11:0]  num_waveforms,
  output logic [15:0]  channel_tag,
  output logic         fill_done,
  output logic         fill_ok,
  output logic [4:0]   err
);

  typedef enum logic [1:0] {IDLE, WHDR, DATA, CSUM} state_t;

  localparam logic [3:0] TAG_FILL = 4'd1;
  localparam logic [3:0] TAG_WHDR = 4'd2;
  localparam logic [3:0] TAG_DATA = 4'd3;
  localparam logic [3:0] TAG_CSUM = 4'd4;

  state_t        state, state_nxt;
  logic [127:0]  acc, acc_nxt;
  logic [11:0]   wcnt, wcnt_nxt;
  logic [22:0]   bcnt, bcnt_nxt;
  logic [4:0]    err_nxt;
  logic [23:0]   fill_num_nxt;
  logic [1:0]    fill_type_nxt;
  logic [22:0]   num_fill_bursts_nxt;
  logic [11:0]   num_waveforms_nxt;
  logic [15:0]   channel_tag_nxt;
  logic [127:0]  smp_dat_nxt;
  logic [11:0]   smp_wfm_num_nxt;
  logic          smp_last_nxt;
  logic          smp_valid_nxt;
  logic          fill_done_nxt;
  logic          fill_ok_nxt;

  logic [3:0]    tag;
  logic [127:0]  word;
  logic          accept;
  logic          hdr_word;
  logic          last_wfm;
  logic [11:0]   exp_wfm_num;
  logic [127:0]  smp_ext;
  logic          abort;
  logic          take_hdr;

  assign tag         = in_dat[131:128];
  assign word        = in_dat[127:0];
  assign accept      = in_valid && in_ready;
  assign hdr_word    = (tag == TAG_FILL) && (word[127:126] == 2'b01);
  assign last_wfm    = ((wcnt + 12'd1) == num_waveforms);
  assign exp_wfm_num = FIRST_WFM_NUM + wcnt;

  // The sample register is the only buffer, so data words may only be taken
  // when it is empty or being drained this cycle.
  assign in_ready = (state == DATA) ? (!smp_valid || smp_ready) : 1'b1;

  // Each 12-bit ADC code is sign-extended from bit 11; the stored upper
  // nibble is ignored.
  always_comb begin
    smp_ext = '0;
    for (int k = 0; k < 8; k++) begin
      smp_ext[16*k +: 16] = {{4{word[16*k+11]}}, word[16*k +: 12]};
    end
  end

  // Next-state and next-output logic. An unexpected tag aborts the fill; if
  // that word is itself a valid fill header it starts the next fill at once
  // so no header is lost when the stream resynchronises.
  always_comb begin
    state_nxt           = state;
    acc_nxt             = acc;
    wcnt_nxt            = wcnt;
    bcnt_nxt            = bcnt;
    err_nxt             = err;
    fill_num_nxt        = fill_num;
    fill_type_nxt       = fill_type;
    num_fill_bursts_nxt = num_fill_bursts;
    num_waveforms_nxt   = num_waveforms;
    channel_tag_nxt     = channel_tag;
    smp_dat_nxt         = smp_dat;
    smp_wfm_num_nxt     = smp_wfm_num;
    smp_last_nxt        = smp_last;
    smp_valid_nxt       = smp_valid && !smp_ready;
    fill_done_nxt       = 1'b0;
    fill_ok_nxt         = 1'b0;
    abort               = 1'b0;
    take_hdr            = 1'b0;

    if (accept) begin
      case (state)
        IDLE: take_hdr = hdr_word;
        WHDR: begin
          if (tag != TAG_WHDR) begin
            abort = 1'b1;
          end else begin
            acc_nxt = acc ^ word;
            if (word[127:126] != 2'b01) err_nxt[1] = 1'b1;
            if (word[24:23] != fill_type || word[63:52] != num_waveforms ||
                word[113:98] != channel_tag) err_nxt[2] = 1'b1;
            if (word[75:64] != exp_wfm_num) err_nxt[3] = 1'b1;
            bcnt_nxt = word[22:0];
            if (word[22:0] == 23'd0) begin
              wcnt_nxt  = wcnt + 12'd1;
              state_nxt = last_wfm ? CSUM : WHDR;
            end else begin
              state_nxt = DATA;
            end
          end
        end
        DATA: begin
          if (tag != TAG_DATA) begin
            abort = 1'b1;
          end else begin
            acc_nxt         = acc ^ word;
            smp_valid_nxt   = 1'b1;
            smp_dat_nxt     = smp_ext;
            smp_wfm_num_nxt = exp_wfm_num;
            smp_last_nxt    = (bcnt == 23'd1);
            if (bcnt == 23'd1) begin
              wcnt_nxt  = wcnt + 12'd1;
              state_nxt = last_wfm ? CSUM : WHDR;
            end else begin
              bcnt_nxt = bcnt - 23'd1;
            end
          end
        end
        CSUM: begin
          if (tag != TAG_CSUM) begin
            abort = 1'b1;
          end else begin
            err_nxt[4]    = (word != acc);
            fill_done_nxt = 1'b1;
            fill_ok_nxt   = (err[3:0] == 4'd0) && (word == acc);
            state_nxt     = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (abort) begin
        err_nxt[0]    = 1'b1;
        fill_done_nxt = 1'b1;
        fill_ok_nxt   = 1'b0;
        state_nxt     = IDLE;
        take_hdr      = hdr_word;
      end

      if (take_hdr) begin
        fill_num_nxt        = word[23:0];
        fill_type_nxt       = word[25:24];
        num_fill_bursts_nxt = word[49:27];
        num_waveforms_nxt   = word[87:76];
        channel_tag_nxt     = word[125:110];
        acc_nxt             = word;
        wcnt_nxt            = 12'd0;
        err_nxt             = 5'd0;
        state_nxt           = (word[87:76] == 12'd0) ? CSUM : WHDR;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      acc             <= '0;
      wcnt            <= '0;
      bcnt            <= '0;
      err             <= '0;
      fill_num        <= '0;
      fill_type       <= '0;
      num_fill_bursts <= '0;
      num_waveforms   <= '0;
      channel_tag     <= '0;
      smp_dat         <= '0;
      smp_wfm_num     <= '0;
      smp_last        <= 1'b0;
      smp_valid       <= 1'b0;
      fill_done       <= 1'b0;
      fill_ok         <= 1'b0;
    end else begin
      state           <= state_nxt;
      acc             <= acc_nxt;
      wcnt            <= wcnt_nxt;
      bcnt            <= bcnt_nxt;
      err             <= err_nxt;
      fill_num        <= fill_num_nxt;
      fill_type       <= fill_type_nxt;
      num_fill_bursts <= num_fill_bursts_nxt;
      num_waveforms   <= num_waveforms_nxt;
      channel_tag     <= channel_tag_nxt;
      smp_dat         <= smp_dat_nxt;
      smp_wfm_num     <= smp_wfm_num_nxt;
      smp_last        <= smp_last_nxt;
      smp_valid       <= smp_valid_nxt;
      fill_done       <= fill_done_nxt;
      fill_ok         <= fill_ok_nxt;
    end
  end

endmodule

// File: tb/tb_adc_dat_demux.sv
// tb_adc_dat_demux
// Self-checking bench for adc_dat_demux. Words are built from field values,
// the XOR checksum is tracked independently, and every data word pushes its
// expected sample word to a scoreboard that is drained as smp_* handshakes.
module tb_adc_dat_demux;

  localparam logic [11:0] FIRST_WFM_NUM = 12'd0;

  logic         clk = 1'b0;
  logic         reset;
  logic [131:0] in_dat;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] smp_dat;
  logic [11:0]  smp_wfm_num;
  logic         smp_last;
  logic         smp_valid;
  logic         smp_ready;
  logic [23:0]  fill_num;
  logic [1:0]   fill_type;
  logic [22:0]  num_fill_bursts;
  logic [11:0]  num_waveforms;
  logic [15:0]  channel_tag;
  logic         fill_done;
  logic         fill_ok;
  logic [4:0]   err;

  adc_dat_demux #(.FIRST_WFM_NUM(FIRST_WFM_NUM)) dut (
    .clk(clk), .reset(reset),
    .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .smp_dat(smp_dat), .smp_wfm_num(smp_wfm_num), .smp_last(smp_last),
    .smp_valid(smp_valid), .smp_ready(smp_ready),
    .fill_num(fill_num), .fill_type(fill_type),
    .num_fill_bursts(num_fill_bursts), .num_waveforms(num_waveforms),
    .channel_tag(channel_tag),
    .fill_done(fill_done), .fill_ok(fill_ok), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] dat;
    logic [11:0]  wfm;
    logic         last;
  } smp_t;

  smp_t         sb[$];
  smp_t         exp_smp;
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_popped = 0;
  logic [127:0] acc_m;
  logic [1:0]   cur_type;
  logic [11:0]  cur_nwf;
  logic [15:0]  cur_tag;

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference unpacking via signed assignment.
  function automatic logic [127:0] expand(input logic [127:0] d);
    logic [127:0]       r;
    logic signed [11:0] s;
    logic signed [15:0] e;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      s = d[16*k +: 12];
      e = s;
      r[16*k +: 16] = e;
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [131:0] w);
    int cyc;
    cyc = 0;
    in_dat   = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 128'(in_ready), 128'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendHdr(input logic [23:0] fnum, input logic [1:0] ftype,
                         input logic [22:0] bursts, input logic [11:0] nwf,
                         input logic [15:0] ctag);
    logic [131:0] w;
    w = '0;
    w[75:50]   = 26'($urandom);
    w[131:128] = 4'd1;
    w[127:126] = 2'b01;
    w[23:0]    = fnum;
    w[25:24]   = ftype;
    w[49:27]   = bursts;
    w[87:76]   = nwf;
    w[125:110] = ctag;
    acc_m    = w[127:0];
    cur_type = ftype;
    cur_nwf  = nwf;
    cur_tag  = ctag;
    applyStimulus(w);
  endtask

  task automatic sendWhdr(input logic [11:0] wnum, input logic [22:0] bursts);
    logic [131:0] w;
    w = '0;
    w[131:128] = 4'd2;
    w[127:126] = 2'b01;
    w[22:0]    = bursts;
    w[24:23]   = cur_type;
    w[63:52]   = cur_nwf;
    w[75:64]   = wnum;
    w[113:98]  = cur_tag;
    acc_m = acc_m ^ w[127:0];
    applyStimulus(w);
  endtask

  task automatic sendData(input logic [127:0] d, input logic [11:0] wfm,
                          input logic last);
    smp_t e;
    e.dat  = expand(d);
    e.wfm  = wfm;
    e.last = last;
    sb.push_back(e);
    acc_m = acc_m ^ d;
    applyStimulus({4'd3, d});
  endtask

  task automatic sendWfm(input int idx, input logic [11:0] wnum, input int bursts);
    sendWhdr(wnum, 23'(bursts));
    for (int b = 0; b < bursts; b++)
      sendData(rand128(), FIRST_WFM_NUM + 12'(idx), b == bursts - 1);
  endtask

  task automatic sendCsum(input logic [127:0] flip, input logic exp_ok,
                          input logic [4:0] exp_err);
    applyStimulus({4'd4, acc_m ^ flip});
    checkOutput("fill_done", 128'(fill_done), 128'd1);
    checkOutput("fill_ok", 128'(fill_ok), 128'(exp_ok));
    checkOutput("err", 128'(err), 128'(exp_err));
    checkOutput("sb_empty", 128'(sb.size()), 128'd0);
  endtask

  // Scoreboard drain on every sample handshake.
  always @(negedge clk) begin
    if (!reset && smp_valid && smp_ready) begin
      if (sb.size() == 0) begin
        checkOutput("smp_unexpected", 128'(smp_valid), 128'd0);
      end else begin
        exp_smp = sb.pop_front();
        n_popped++;
        checkOutput("smp_dat", smp_dat, exp_smp.dat);
        checkOutput("smp_wfm_num", 128'(smp_wfm_num), 128'(exp_smp.wfm));
        checkOutput("smp_last", 128'(smp_last), 128'(exp_smp.last));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] d;
    logic [131:0] w;
    int           p0;

    reset     = 1'b1;
    in_dat    = '0;
    in_valid  = 1'b0;
    smp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_smp_valid", 128'(smp_valid), 128'd0);
    checkOutput("rst_smp_dat", smp_dat, 128'd0);
    checkOutput("rst_fill_done", 128'(fill_done), 128'd0);
    checkOutput("rst_fill_ok", 128'(fill_ok), 128'd0);
    checkOutput("rst_err", 128'(err), 128'd0);
    checkOutput("rst_fill_num", 128'(fill_num), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] normal fill: 2 waveforms x 3 bursts");
    p0 = n_popped;
    sendHdr(24'hABCDE1, 2'd2, 23'h4A5A5A, 12'd2, 16'hBEEF);
    checkOutput("hdr_fill_num", 128'(fill_num), 128'h0ABCDE1);
    checkOutput("hdr_fill_type", 128'(fill_type), 128'd2);
    checkOutput("hdr_bursts", 128'(num_fill_bursts), 128'h4A5A5A);
    checkOutput("hdr_nwf", 128'(num_waveforms), 128'd2);
    checkOutput("hdr_channel_tag", 128'(channel_tag), 128'hBEEF);
    sendWfm(0, FIRST_WFM_NUM, 3);
    sendWfm(1, FIRST_WFM_NUM + 12'd1, 3);
    sendCsum('0, 1'b1, 5'd0);
    checkOutput("sample_count", 128'(n_popped - p0), 128'd6);

    $display("[TB] sign extension lanes");
    sendHdr(24'd7, 2'd1, 23'd1, 12'd1, 16'h1234);
    sendWhdr(FIRST_WFM_NUM, 23'd1);
    d = rand128();
    d[15:0]  = 16'h0800;
    d[31:16] = 16'hA7FF;
    sendData(d, FIRST_WFM_NUM, 1'b1);
    checkOutput("lane0_neg", 128'(smp_dat[15:0]), 128'hF800);
    checkOutput("lane1_pos", 128'(smp_dat[31:16]), 128'h07FF);
    sendCsum('0, 1'b1, 5'd0);

    $display("[TB] checksum bit 5 flipped");
    sendHdr(24'h000123, 2'd0, 23'd3, 12'd2, 16'h5555);
    sendWfm(0, FIRST_WFM_NUM, 3);
    sendWfm(1, FIRST_WFM_NUM + 12'd1, 3);
    sendCsum(128'h20, 1'b0, 5'b10000);

    $display("[TB] downstream stall mid-waveform");
    sendHdr(24'h000200, 2'd3, 23'd3, 12'd2, 16'h0F0F);
    sendWhdr(FIRST_WFM_NUM, 23'd3);
    smp_ready = 1'b0;
    d = rand128();
    sendData(d, FIRST_WFM_NUM, 1'b0);
    w = {4'd3, rand128()};
    in_dat   = w;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 128'(in_ready), 128'd0);
      checkOutput("stall_smp_dat", smp_dat, expand(d));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    smp_ready = 1'b1;
    sendData(w[127:0], FIRST_WFM_NUM, 1'b0);
    sendData(rand128(), FIRST_WFM_NUM, 1'b1);
    sendWfm(1, FIRST_WFM_NUM + 12'd1, 3);
    sendCsum('0, 1'b1, 5'd0);

    $display("[TB] unexpected checksum tag during data");
    sendHdr(24'h000300, 2'd1, 23'd3, 12'd2, 16'h2222);
    sendWhdr(FIRST_WFM_NUM, 23'd3);
    sendData(rand128(), FIRST_WFM_NUM, 1'b0);
    applyStimulus({4'd4, rand128()});
    checkOutput("abort_fill_done", 128'(fill_done), 128'd1);
    checkOutput("abort_fill_ok", 128'(fill_ok), 128'd0);
    checkOutput("abort_err", 128'(err), 128'b00001);

    $display("[TB] fill header during data resyncs");
    sendHdr(24'h000400, 2'd1, 23'd3, 12'd2, 16'h3333);
    sendWhdr(FIRST_WFM_NUM, 23'd3);
    sendData(rand128(), FIRST_WFM_NUM, 1'b0);
    sendData(rand128(), FIRST_WFM_NUM, 1'b0);
    sendHdr(24'h000401, 2'd2, 23'd2, 12'd1, 16'h4444);
    checkOutput("resync_fill_done", 128'(fill_done), 128'd1);
    checkOutput("resync_fill_ok", 128'(fill_ok), 128'd0);
    checkOutput("resync_fill_num", 128'(fill_num), 128'h000401);
    sendWfm(0, FIRST_WFM_NUM, 2);
    sendCsum('0, 1'b1, 5'd0);

    $display("[TB] waveform number out of sequence");
    sendHdr(24'h000500, 2'd0, 23'd2, 12'd2, 16'h6666);
    sendWfm(0, FIRST_WFM_NUM, 2);
    sendWfm(1, FIRST_WFM_NUM + 12'd5, 2);
    sendCsum('0, 1'b0, 5'b01000);

    $display("[TB] fill with no waveforms");
    sendHdr(24'h000600, 2'd1, 23'd0, 12'd0, 16'h7777);
    sendCsum('0, 1'b1, 5'd0);

    $display("[TB] reset during data");
    sendHdr(24'h000700, 2'd1, 23'd3, 12'd2, 16'h8888);
    sendWhdr(FIRST_WFM_NUM, 23'd3);
    sendData(rand128(), FIRST_WFM_NUM, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_smp_valid", 128'(smp_valid), 128'd0);
    checkOutput("mid_rst_smp_dat", smp_dat, 128'd0);
    checkOutput("mid_rst_fill_num", 128'(fill_num), 128'd0);
    checkOutput("mid_rst_fill_done", 128'(fill_done), 128'd0);
    checkOutput("mid_rst_err", 128'(err), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_fill_done", 128'(fill_done), 128'd0);
    checkOutput("post_rst_sb_empty", 128'(sb.size()), 128'd0);
    sendHdr(24'h000800, 2'd3, 23'd2, 12'd1, 16'h9999);
    checkOutput("post_rst_fill_num", 128'(fill_num), 128'h000800);
    sendWfm(0, FIRST_WFM_NUM, 2);
    sendCsum('0, 1'b1, 5'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
